mmio_io_controller: RTL and testbench
=====================================

# mmio_io_controller

Memory-mapped I/O controller sitting between the MIPS IO port (IOAddr/IOWriteEn/IOWriteData/IOReadData) and the board peripherals. It decodes the 4-bit IO address into a display register, a debounced speed-switch register, and a programmable game-tick timer with sticky status. It also sequences the 4-digit multiplexed 7-segment scan. It replaces ad-hoc decode in the top level and gives the snake software a hardware tick instead of busy-wait delay loops.

## Interface
Parameters:
- SCAN_BITS, 16: width of the display scan counter; the top 2 bits select the digit.
- DEBOUNCE_CYCLES, 100000: consecutive stable cycles required before a switch change is accepted (10 ms at 10 MHz).
- TIMER_W, 24: width of the tick period and down-counter.

Ports:
- CLK  in  1  system clock (10 MHz divided clock).
- RESET  in  1  asynchronous, active-high.
- IOAddr  in  4  IO address from the processor.
- IOWriteEn  in  1  IO write strobe, one cycle per store.
- IOWriteData  in  32  IO store data.
- IOReadData  out  32  IO load data (combinational).
- SPEEDSWITCHES  in  2  raw, asynchronous board switches.
- AN  out  4  digit enables, active-low.
- LED  out  7  segment lines, active-low.

## Operation
Address map; writes to all other addresses are ignored and reads of them return 0:
- 0x0 DISP: write sets disp_reg[27:0] = IOWriteData[27:0]; read returns {4'b0, disp_reg}.
- 0x4 SPEED: read-only; returns {30'b0, sw_db}; writes are ignored.
- 0x8 PERIOD: write sets period = IOWriteData[TIMER_W-1:0] and loads the counter with that value; read returns a zero-extended period.
- 0xC STATUS: read returns {30'b0, overrun, tick}; any write clears tick and overrun.

Timer:
- period == 0: timer disabled; the counter holds and no ticks are produced.
- Otherwise the counter decrements each cycle. On the cycle it equals 1, it reloads with period and raises a tick event, so ticks occur every `period` cycles.
- Tick event while tick is already set: overrun is set as well.
- Tick event in the same cycle as a STATUS write: tick is set and overrun is cleared, so the set wins and no tick is lost.

Switch path:
- Each switch bit passes through a 2-flop synchronizer.
- A per-bit stability counter resets whenever the synchronized value differs from sw_db.
- When the counter reaches DEBOUNCE_CYCLES-1, sw_db takes the synchronized value.

Display scan:
- The free-running scan counter increments every cycle and wraps.
- The top 2 bits select the digit: 00 gives AN=1110 with disp_reg[6:0]; 01 gives AN=1101 with [13:7]; 10 gives AN=1011 with [20:14]; 11 gives AN=0111 with [27:21].
- LED = ~selected 7-bit field, so a 1 in disp_reg lights the segment.

## Timing
- Reset values: disp_reg=0, period=0, counter=0, tick=0, overrun=0, sw_db=00, synchronizers=0, scan counter=0. AN=1110 and LED=7'h7F while in reset.
- Writes take effect at the CLK edge on which IOWriteEn=1. A read of the same register in the next cycle returns the new value.
- IOReadData is purely combinational from IOAddr and register state, with zero-cycle read latency.
- A tick becomes visible in STATUS on the cycle after the counter equals 1.
- A PERIOD write during counting restarts the count immediately. The tick flag is unchanged.
- A switch change is reflected in sw_db 2 + DEBOUNCE_CYCLES cycles after the input edge, provided the input stays stable. A glitch shorter than that produces no change.
- RESET asserted mid-count or mid-debounce returns everything to reset values asynchronously. Counting resumes only after a new PERIOD write.

## Structure
- Package io_map_pkg holds:
  - address constants ADDR_DISP=4'h0, ADDR_SPEED=4'h4, ADDR_PERIOD=4'h8, ADDR_STATUS=4'hC;
  - the STATUS bit indices TICK_BIT=0, OVR_BIT=1;
  - the digit-select encoding.
- Sub-module switch_debouncer (parameter DEBOUNCE_CYCLES, width 1) contains the synchronizer and stability counter. It is instantiated once per switch bit.
- Timer, address decode and scan logic stay in mmio_io_controller.

## Test plan
- Display write: write 0x0 = 0x0ABCDEF5 → read 0x0 returns 0x0ABCDEF5. With SCAN_BITS=4 and scan counter 0..3, AN=1110 gives LED=~7'h75, and AN=0111 gives LED=~7'h55.
- Debounce: with DEBOUNCE_CYCLES=8, set SPEEDSWITCHES=2'b10.
  - Read 0x4 returns 0 until cycle 10 after the edge, then returns 2.
  - A 5-cycle pulse to 01 leaves the read value at 2.
- Timer period: write 0x8 = 5 → tick is set every 5 cycles. Reading 0xC returns 1 after the first tick; a write to 0xC clears it.
- Overrun: with period 3 and no clear for 7 cycles → STATUS reads 3. A STATUS write in the same cycle as a tick event → STATUS reads 1 next cycle.
- Disabled timer and unmapped address: write 0x8 = 0 → no tick for 1000 cycles. Read of 0x2 returns 0; a write to 0x6 changes no register.
- Reset mid-operation: assert RESET during counting with disp_reg set → every register reads 0, AN=1110, LED=7'h7F, and no tick occurs until PERIOD is rewritten.

Source files
------------

// File: rtl/io_map_pkg.sv
// Purpose : shared IO address map, STATUS bit positions and 7-seg digit-select encoding.
// Latency : n/a (constants, types and a pure function only).
// Backpressure: n/a.
package io_map_pkg;

    localparam logic [3:0] ADDR_DISP   = 4'h0;
    localparam logic [3:0] ADDR_SPEED  = 4'h4;
    localparam logic [3:0] ADDR_PERIOD = 4'h8;
    localparam logic [3:0] ADDR_STATUS = 4'hC;

    localparam int TICK_BIT = 0;
    localparam int OVR_BIT  = 1;

    localparam int DISP_W = 28;
    localparam int SEG_W  = 7;

    // Digit select is the top two bits of the scan counter; digit n shows disp[7n+6:7n].
    typedef enum logic [1:0] {
        DIGIT_0 = 2'd0,
        DIGIT_1 = 2'd1,
        DIGIT_2 = 2'd2,
        DIGIT_3 = 2'd3
    } digit_sel_e;

    // Active-low anode pattern for a selected digit.
    function automatic logic [3:0] digit_anode(input digit_sel_e d);
        case (d)
            DIGIT_0: return 4'b1110;
            DIGIT_1: return 4'b1101;
            DIGIT_2: return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

endpackage

// File: rtl/mmio_io_controller_switch_debouncer.sv
// Purpose : 2-flop synchronizer plus stability counter for one raw board switch.
// Latency : an input change that stays stable appears on sw_db 2 + DEBOUNCE_CYCLES cycles later.
// Backpressure: none; free-running.
// Ports   : CLK, RESET (async, active-high), sw_raw (asynchronous switch), sw_db (debounced level).
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic sw_raw,
    output logic sw_db
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    // The counter only runs while the synchronized level disagrees with the
    // accepted level; any return to agreement restarts the stability window.
    always_comb begin
        sync1_d = sw_raw;
        sync2_d = sync1_q;
        db_d    = db_q;
        cnt_d   = '0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                db_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign sw_db = db_q;

endmodule

// File: rtl/mmio_io_controller.sv
// Purpose : MIPS IO-port decode for display, debounced speed switches and game-tick timer; 7-seg scan.
// Latency : writes land on the CLK edge with IOWriteEn=1; IOReadData is combinational (0 cycles).
// Backpressure: none; every IO access completes in its own cycle.
// Ports   : CLK, RESET (async, active-high), IOAddr/IOWriteEn/IOWriteData/IOReadData (processor IO),
//           SPEEDSWITCHES (raw switches), AN (active-low digit enables), LED (active-low segments).
module mmio_io_controller
    import io_map_pkg::*;
#(
    parameter int SCAN_BITS       = 16,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int TIMER_W         = 24
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [3:0]  IOAddr,
    input  logic        IOWriteEn,
    input  logic [31:0] IOWriteData,
    output logic [31:0] IOReadData,
    input  logic [1:0]  SPEEDSWITCHES,
    output logic [3:0]  AN,
    output logic [6:0]  LED
);

    logic [DISP_W-1:0]    disp_q, disp_d;
    logic [TIMER_W-1:0]   period_q, period_d;
    logic [TIMER_W-1:0]   count_q, count_d;
    logic                 tick_q, tick_d;
    logic                 ovr_q, ovr_d;
    logic [SCAN_BITS-1:0] scan_q, scan_d;
    logic [1:0]           sw_db;
    logic                 tick_evt;
    digit_sel_e           digit;
    logic [SEG_W-1:0]     seg;

    logic wr_disp, wr_period, wr_status;
    assign wr_disp   = IOWriteEn && (IOAddr == ADDR_DISP);
    assign wr_period = IOWriteEn && (IOAddr == ADDR_PERIOD);
    assign wr_status = IOWriteEn && (IOAddr == ADDR_STATUS);

    // Upper store-data bits have no destination register.
    logic unused_wdata;
    assign unused_wdata = ^IOWriteData[31:DISP_W];

    for (genvar i = 0; i < 2; i++) begin : g_sw
        switch_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debouncer (
            .CLK   (CLK),
            .RESET (RESET),
            .sw_raw(SPEEDSWITCHES[i]),
            .sw_db (sw_db[i])
        );
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            disp_q   <= '0;
            period_q <= '0;
            count_q  <= '0;
            tick_q   <= 1'b0;
            ovr_q    <= 1'b0;
            scan_q   <= '0;
        end else begin
            disp_q   <= disp_d;
            period_q <= period_d;
            count_q  <= count_d;
            tick_q   <= tick_d;
            ovr_q    <= ovr_d;
            scan_q   <= scan_d;
        end
    end

    always_comb begin
        disp_d   = disp_q;
        period_d = period_q;
        count_d  = count_q;
        tick_d   = tick_q;
        ovr_d    = ovr_q;
        tick_evt = 1'b0;
        scan_d   = scan_q + SCAN_BITS'(1);

        if (wr_disp) begin
            disp_d = IOWriteData[DISP_W-1:0];
        end

        // A PERIOD store restarts the count from the new value and
        // pre-empts any reload/tick that would have happened this cycle.
        if (wr_period) begin
            period_d = IOWriteData[TIMER_W-1:0];
            count_d  = IOWriteData[TIMER_W-1:0];
        end else if (period_q != '0) begin
            if (count_q == TIMER_W'(1)) begin
                count_d  = period_q;
                tick_evt = 1'b1;
            end else begin
                count_d = count_q - TIMER_W'(1);
            end
        end

        if (tick_evt) begin
            tick_d = 1'b1;
            if (tick_q) begin
                ovr_d = 1'b1;
            end
        end

        // Clearing STATUS drops overrun unconditionally, but a tick landing in
        // the same cycle survives so software never misses it.
        if (wr_status) begin
            ovr_d = 1'b0;
            if (!tick_evt) begin
                tick_d = 1'b0;
            end
        end
    end

    always_comb begin
        IOReadData = '0;
        case (IOAddr)
            ADDR_DISP:   IOReadData = {4'b0, disp_q};
            ADDR_SPEED:  IOReadData = {30'b0, sw_db};
            ADDR_PERIOD: IOReadData = 32'(period_q);
            ADDR_STATUS: begin
                IOReadData[TICK_BIT] = tick_q;
                IOReadData[OVR_BIT]  = ovr_q;
            end
            default:     IOReadData = '0;
        endcase
    end

    always_comb begin
        digit = digit_sel_e'(scan_q[SCAN_BITS-1 -: 2]);
        case (digit)
            DIGIT_0: seg = disp_q[6:0];
            DIGIT_1: seg = disp_q[13:7];
            DIGIT_2: seg = disp_q[20:14];
            default: seg = disp_q[27:21];
        endcase
        AN  = digit_anode(digit);
        LED = ~seg;
    end

endmodule

// File: tb/tb_mmio_io_controller.sv
`timescale 1ns/1ps
module tb_mmio_io_controller;

    localparam int SCAN_BITS = 4;
    localparam int DEB       = 8;
    localparam int TW        = 24;
    localparam int HIST      = 8192;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [3:0]  IOAddr = 4'h0;
    logic        IOWriteEn = 1'b0;
    logic [31:0] IOWriteData = '0;
    logic [31:0] IOReadData;
    logic [1:0]  SPEEDSWITCHES = 2'b00;
    logic [3:0]  AN;
    logic [6:0]  LED;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    mmio_io_controller #(
        .SCAN_BITS(SCAN_BITS),
        .DEBOUNCE_CYCLES(DEB),
        .TIMER_W(TW)
    ) dut (
        .CLK(CLK),
        .RESET(RESET),
        .IOAddr(IOAddr),
        .IOWriteEn(IOWriteEn),
        .IOWriteData(IOWriteData),
        .IOReadData(IOReadData),
        .SPEEDSWITCHES(SPEEDSWITCHES),
        .AN(AN),
        .LED(LED)
    );

    // Behavioural model: timer ticks are arithmetic on edge numbers since the
    // last PERIOD load; debounce is a window test over the sampled-input history.
    int         e = 0;
    logic [27:0] m_disp = '0;
    int         m_period = 0;
    int         m_load = 0;
    bit         m_tick = 0;
    bit         m_ovr = 0;
    logic [1:0] m_db = 2'b00;
    int         m_scan = 0;
    logic [1:0] samp [0:HIST-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] get_samp(input int i);
        if (i < 0) return 2'b00;
        return samp[i % HIST];
    endfunction

    function automatic logic [31:0] m_read(input logic [3:0] a);
        case (a)
            4'h0:    return {4'b0, m_disp};
            4'h4:    return {30'b0, m_db};
            4'h8:    return 32'(m_period);
            4'hC:    return {30'b0, m_ovr, m_tick};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge CLK) begin : model
        bit evt, wr_p, wr_s, all_diff;
        logic [1:0] s;
        logic [3:0] one;
        logic [3:0] exp_an;
        logic [6:0] exp_led;
        int dig;
        e++;
        if (RESET) begin
            samp[e % HIST] = 2'b00;
            m_disp = '0; m_period = 0; m_load = 0; m_tick = 0; m_ovr = 0;
            m_db = 2'b00; m_scan = 0;
        end else begin
            samp[e % HIST] = SPEEDSWITCHES;
            wr_p = IOWriteEn && (IOAddr == 4'h8);
            wr_s = IOWriteEn && (IOAddr == 4'hC);
            evt = !wr_p && (m_period != 0) && ((e - m_load) > 0) && (((e - m_load) % m_period) == 0);
            if (IOWriteEn && (IOAddr == 4'h0)) m_disp = IOWriteData[27:0];
            if (wr_p) begin
                m_period = int'(IOWriteData[TW-1:0]);
                m_load = e;
            end
            if (evt) begin
                if (m_tick) m_ovr = 1;
                m_tick = 1;
            end
            if (wr_s) begin
                m_ovr = 0;
                if (!evt) m_tick = 0;
            end
            // A bit flips once the last DEB synchronized samples all disagree with it.
            for (int b = 0; b < 2; b++) begin
                all_diff = 1;
                for (int k = 2; k <= DEB + 1; k++) begin
                    s = get_samp(e - k);
                    if (s[b] == m_db[b]) all_diff = 0;
                end
                if (all_diff) m_db[b] = ~m_db[b];
            end
            m_scan = (m_scan + 1) % (1 << SCAN_BITS);
        end
        #1;
        dig = m_scan >> (SCAN_BITS - 2);
        one = 4'b0001;
        exp_an = ~(one << dig);
        exp_led = ~m_disp[dig*7 +: 7];
        check("cyc_read", IOReadData, m_read(IOAddr));
        check("cyc_an", {28'b0, AN}, {28'b0, exp_an});
        check("cyc_led", {25'b0, LED}, {25'b0, exp_led});
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge CLK);
        IOAddr = a;
        IOWriteEn = 1'b1;
        IOWriteData = d;
        @(negedge CLK);
        IOWriteEn = 1'b0;
    endtask

    task automatic rd_chk(input string n, input logic [3:0] a, input logic [31:0] exp);
        IOAddr = a;
        #1;
        check(n, IOReadData, exp);
    endtask

    localparam logic [6:0] SEG_LO = 7'h75;
    localparam logic [6:0] SEG_HI = 7'h55;

    initial begin : stim
        bit found;
        int r;
        logic [3:0] a;

        RESET = 1'b1;
        repeat (3) @(negedge CLK);
        rd_chk("rst_disp", 4'h0, 32'h0);
        check("rst_an", {28'b0, AN}, 32'h0000000E);
        check("rst_led", {25'b0, LED}, 32'h0000007F);
        @(negedge CLK);
        RESET = 1'b0;

        // Display register and scan.
        wr(4'h0, 32'h0ABCDEF5);
        rd_chk("disp_rd", 4'h0, 32'h0ABCDEF5);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            if (AN == 4'b0111) begin
                found = 1;
                check("scan_d3_led", {25'b0, LED}, {25'b0, ~SEG_HI});
            end
        end
        check("scan_d3_seen", {31'b0, found}, 32'd1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            if (AN == 4'b1110) begin
                found = 1;
                check("scan_d0_led", {25'b0, LED}, {25'b0, ~SEG_LO});
            end
        end
        check("scan_d0_seen", {31'b0, found}, 32'd1);

        // Debounce: change accepted 2 + DEB cycles after the edge.
        @(negedge CLK);
        SPEEDSWITCHES = 2'b10;
        IOAddr = 4'h4;
        for (int c = 1; c <= 12; c++) begin
            @(negedge CLK);
            if (c == 9)  check("deb_before", IOReadData, 32'd0);
            if (c == 10) check("deb_after", IOReadData, 32'd2);
        end
        SPEEDSWITCHES = 2'b01;
        repeat (5) @(negedge CLK);
        SPEEDSWITCHES = 2'b10;
        repeat (20) @(negedge CLK);
        check("deb_glitch", IOReadData, 32'd2);

        // Timer period 5.
        wr(4'h8, 32'd5);
        IOAddr = 4'hC;
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK);
            if (c == 4) check("tmr_pre", IOReadData, 32'd0);
            if (c == 5) check("tmr_tick", IOReadData, 32'd1);
        end
        wr(4'hC, 32'd0);
        rd_chk("tmr_clear", 4'hC, 32'd0);
        repeat (4) @(negedge CLK);
        check("tmr_tick2", IOReadData, 32'd1);

        // Overrun, then clear racing a tick.
        wr(4'h8, 32'd3);
        wr(4'hC, 32'd0);
        IOAddr = 4'hC;
        repeat (7) @(negedge CLK);
        check("ovr_set", IOReadData, 32'd3);
        for (int i = 0; i < 10 && (((e + 1 - m_load) % m_period) != 0); i++) @(negedge CLK);
        IOAddr = 4'hC;
        IOWriteEn = 1'b1;
        @(negedge CLK);
        IOWriteEn = 1'b0;
        check("clr_vs_tick", IOReadData, 32'd1);

        // Disabled timer and unmapped addresses.
        wr(4'h8, 32'd0);
        wr(4'hC, 32'd0);
        IOAddr = 4'hC;
        repeat (1000) @(negedge CLK);
        check("disabled", IOReadData, 32'd0);
        rd_chk("unmapped_rd", 4'h2, 32'd0);
        wr(4'h6, 32'hFFFFFFFF);
        rd_chk("unmapped_disp", 4'h0, 32'h0ABCDEF5);
        rd_chk("unmapped_per", 4'h8, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge CLK);
            r = $urandom_range(0, 7);
            case (r)
                0: a = 4'h0;
                1: a = 4'h4;
                2, 3: a = 4'h8;
                4: a = 4'hC;
                default: a = 4'($urandom_range(0, 15));
            endcase
            IOAddr = a;
            IOWriteEn = ($urandom_range(0, 9) == 0);
            IOWriteData = (a == 4'h8) ? 32'($urandom_range(0, 9)) : $urandom;
            if ($urandom_range(0, 14) == 0) SPEEDSWITCHES = 2'($urandom_range(0, 3));
        end
        @(negedge CLK);
        IOWriteEn = 1'b0;

        // Reset in the middle of counting.
        wr(4'h0, 32'h01234567);
        wr(4'h8, 32'd4);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        rd_chk("mid_rst_disp", 4'h0, 32'd0);
        check("mid_rst_an", {28'b0, AN}, 32'h0000000E);
        check("mid_rst_led", {25'b0, LED}, 32'h0000007F);
        rd_chk("mid_rst_per", 4'h8, 32'd0);
        rd_chk("mid_rst_stat", 4'hC, 32'd0);
        rd_chk("mid_rst_sw", 4'h4, 32'd0);
        SPEEDSWITCHES = 2'b00;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        IOAddr = 4'hC;
        repeat (30) @(negedge CLK);
        check("post_rst_notick", IOReadData, 32'd0);
        wr(4'h8, 32'd2);
        IOAddr = 4'hC;
        repeat (2) @(negedge CLK);
        check("post_rst_tick", IOReadData, 32'd1);

        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
